// File: rtl/mem_stall_ctrl_pkg.sv
// Shared definitions for the memory stall controller: stall bit positions,
// canonical stall patterns and controller state encodings.
package mem_stall_ctrl_pkg;

    localparam int STALL_W  = 5;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;
    localparam int STALL_MW = 4;

    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] HOLD_MEM   = 5'b01111;
    localparam logic [STALL_W-1:0] HOLD_EX    = 5'b00111;
    localparam logic [STALL_W-1:0] KILL_IF    = 5'b00001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } fsm_t;

endpackage

// File: rtl/sat_counter32.sv
// Purpose: 32-bit event counter with synchronous clear, sticks at all-ones.
// Latency: count reflects an enable one cycle after it is sampled.
// Backpressure: none; enable is sampled every cycle.
module sat_counter32 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= 32'd0;
        end else if (en && (cnt != 32'hFFFF_FFFF)) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// Purpose: pipeline stall controller for loads/stores sharing the RAM bus, plus EX multi-cycle holds.
// Latency: stall_o is combinational; first load stall appears 2 cycles after id_stop_req_i.
// Backpressure: holds PC..EX/MEM while the bus access is outstanding, bounded by TIMEOUT.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_stop_req_i,
    input  logic               ex_stall_req_i,
    input  logic               mem_ack_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               bus_busy_o,
    output logic               err_timeout_o,
    output logic [31:0]        stall_cnt_o
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    fsm_t            state;
    fsm_t            state_nxt;
    logic            ex_ls;
    logic [TO_W-1:0] wcnt;
    logic            err;
    logic            in_bus;
    logic            timed_out;
    logic            done;
    logic            go_bus;

    assign in_bus    = (state == ST_BUS);
    assign timed_out = in_bus && (wcnt == TO_LAST);
    assign done      = in_bus && (mem_ack_i || timed_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        stall_o   = STALL_NONE;
        state_nxt = state;

        // A load/store in EX never requests multi-cycle, so its ex_stall is ignored.
        if (rst) begin
            stall_o = STALL_NONE;
        end else if (in_bus && !done) begin
            stall_o = HOLD_MEM;
        end else if (done && ex_stall_req_i) begin
            stall_o = HOLD_EX;
        end else if (done) begin
            stall_o = KILL_IF;
        end else if (ex_stall_req_i && !ex_ls) begin
            stall_o = HOLD_EX;
        end

        go_bus = (stall_o[STALL_EX:STALL_ID] == 2'b00) && ex_ls;

        case (state)
            ST_IDLE: if (go_bus) state_nxt = ST_BUS;
            ST_BUS:  if (done)   state_nxt = go_bus ? ST_BUS : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ls <= 1'b0;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            if (!stall_o[STALL_ID]) begin
                ex_ls <= stall_o[STALL_IF] ? 1'b0 : id_stop_req_i;
            end

            // Restart the wait counter on every entry, including back-to-back accesses.
            if (go_bus && (!in_bus || done)) begin
                wcnt <= '0;
            end else if (in_bus && !done) begin
                wcnt <= wcnt + 1'b1;
            end

            if (timed_out && !mem_ack_i) begin
                err <= 1'b1;
            end
        end
    end

    sat_counter32 u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (stall_o[STALL_PC]),
        .cnt (stall_cnt_o)
    );

    assign bus_busy_o    = in_bus;
    assign err_timeout_o = err;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Bench for mem_stall_ctrl: directed timelines plus random traffic against a
// behavioural model that follows a load token from EX into a bus access.
module tb_mem_stall_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        id_stop_req_i;
    logic        ex_stall_req_i;
    logic        mem_ack_i;
    logic [4:0]  stall_o;
    logic        bus_busy_o;
    logic        err_timeout_o;
    logic [31:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit     m_ls_ex;
    bit     m_bus;
    int     m_age;
    bit     m_err;
    longint m_cnt;

    mem_stall_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_stop_req_i  (id_stop_req_i),
        .ex_stall_req_i (ex_stall_req_i),
        .mem_ack_i      (mem_ack_i),
        .stall_o        (stall_o),
        .bus_busy_o     (bus_busy_o),
        .err_timeout_o  (err_timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_stall();
        bit done;
        done = m_bus && (mem_ack_i || (m_age == TIMEOUT - 1));
        if (rst)                             return 5'b00000;
        if (m_bus && !done)                  return 5'b01111;
        if (done && ex_stall_req_i)          return 5'b00111;
        if (done)                            return 5'b00001;
        if (ex_stall_req_i && !m_ls_ex)      return 5'b00111;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        m_ls_ex = 0; m_bus = 0; m_age = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic drive(input bit stop, input bit exs, input bit ack);
        id_stop_req_i  = stop;
        ex_stall_req_i = exs;
        mem_ack_i      = ack;
        #1;
    endtask

    // Compare against the model, clock once, advance the model.
    task automatic adv();
        logic [4:0] es;
        bit done;
        bit go;
        es = model_stall();
        chk("m_stall", {27'd0, stall_o}, {27'd0, es});
        chk("m_busy",  {31'd0, bus_busy_o}, {31'd0, m_bus});
        chk("m_err",   {31'd0, err_timeout_o}, {31'd0, m_err});
        chk("m_cnt",   stall_cnt_o, m_cnt[31:0]);
        done = m_bus && (mem_ack_i || (m_age == TIMEOUT - 1));
        go   = (es[3:2] == 2'b00) && m_ls_ex;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_bus && !mem_ack_i && (m_age == TIMEOUT - 1)) m_err = 1;
            if (es[0] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_bus && !done) m_age++;
            else if (go) begin m_bus = 1; m_age = 0; end
            else m_bus = 0;
            if (!es[2]) m_ls_ex = es[1] ? 1'b0 : id_stop_req_i;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic exp_step(input string tag, input bit stop, input bit exs, input bit ack,
                            input logic [4:0] es, input bit eb);
        drive(stop, exs, ack);
        chk({tag, "_stall"}, {27'd0, stall_o}, {27'd0, es});
        chk({tag, "_busy"},  {31'd0, bus_busy_o}, {31'd0, eb});
        adv();
    endtask

    initial begin
        int ack_pct;
        logic [31:0] cnt0;
        rst = 1'b1;
        id_stop_req_i = 0; ex_stall_req_i = 0; mem_ack_i = 0;
        do_reset();
        chk("rst_stall", {27'd0, stall_o}, 32'd0);
        chk("rst_busy",  {31'd0, bus_busy_o}, 32'd0);
        chk("rst_err",   {31'd0, err_timeout_o}, 32'd0);
        chk("rst_cnt",   stall_cnt_o, 32'd0);

        // single load
        exp_step("lw_c0", 1, 0, 0, 5'b00000, 0);
        exp_step("lw_c1", 0, 0, 0, 5'b00000, 0);
        exp_step("lw_c2", 0, 0, 0, 5'b01111, 1);
        exp_step("lw_c3", 0, 0, 0, 5'b01111, 1);
        exp_step("lw_c4", 0, 0, 1, 5'b00001, 1);
        exp_step("lw_c5", 0, 0, 0, 5'b00000, 0);
        chk("lw_cnt", stall_cnt_o, 32'd3);

        // back-to-back loads, ack always ready
        exp_step("bb_c0", 1, 0, 1, 5'b00000, 0);
        exp_step("bb_c1", 1, 0, 1, 5'b00000, 0);
        exp_step("bb_c2", 0, 0, 1, 5'b00001, 1);
        exp_step("bb_c3", 0, 0, 1, 5'b00001, 1);
        exp_step("bb_c4", 0, 0, 1, 5'b00000, 0);

        // timeout
        exp_step("to_c0", 1, 0, 0, 5'b00000, 0);
        exp_step("to_c1", 0, 0, 0, 5'b00000, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) exp_step("to_wait", 0, 0, 0, 5'b01111, 1);
        chk("to_err_pre", {31'd0, err_timeout_o}, 32'd0);
        exp_step("to_done", 0, 0, 0, 5'b00001, 1);
        chk("to_err", {31'd0, err_timeout_o}, 32'd1);
        exp_step("to_after", 1, 0, 1, 5'b00000, 0);
        for (int i = 0; i < 4; i++) adv();
        chk("to_sticky", {31'd0, err_timeout_o}, 32'd1);
        do_reset();
        chk("to_clr", {31'd0, err_timeout_o}, 32'd0);

        // EX busy in idle
        cnt0 = stall_cnt_o;
        for (int i = 0; i < 3; i++) exp_step("exb", 0, 1, 0, 5'b00111, 0);
        drive(0, 0, 0);
        chk("exb_cnt", stall_cnt_o, cnt0 + 32'd3);
        chk("exb_end", {27'd0, stall_o}, 32'd0);

        // ack collides with EX busy
        exp_step("col_c0", 1, 0, 0, 5'b00000, 0);
        exp_step("col_c1", 0, 0, 0, 5'b00000, 0);
        exp_step("col_c2", 0, 0, 0, 5'b01111, 1);
        exp_step("col_c3", 0, 1, 1, 5'b00111, 1);
        exp_step("col_c4", 0, 0, 0, 5'b00000, 0);

        // reset during bus wait
        exp_step("rb_c0", 1, 0, 0, 5'b00000, 0);
        exp_step("rb_c1", 0, 0, 0, 5'b00000, 0);
        exp_step("rb_c2", 0, 0, 0, 5'b01111, 1);
        do_reset();
        chk("rb_stall", {27'd0, stall_o}, 32'd0);
        chk("rb_busy",  {31'd0, bus_busy_o}, 32'd0);
        chk("rb_err",   {31'd0, err_timeout_o}, 32'd0);
        chk("rb_cnt",   stall_cnt_o, 32'd0);
        exp_step("rb_lw0", 1, 0, 0, 5'b00000, 0);
        exp_step("rb_lw1", 0, 0, 0, 5'b00000, 0);
        exp_step("rb_lw2", 0, 0, 0, 5'b01111, 1);
        exp_step("rb_lw3", 0, 0, 1, 5'b00001, 1);
        exp_step("rb_lw4", 0, 0, 0, 5'b00000, 0);

        // random traffic with varying ack rates, occasional reset
        for (int blk = 0; blk < 8; blk++) begin
            case (blk % 4)
                0: ack_pct = 60;
                1: ack_pct = 15;
                2: ack_pct = 3;
                default: ack_pct = 100;
            endcase
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end else begin
                    drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                          $urandom_range(0, 99) < ack_pct);
                    adv();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
